// File: rtl/diablo_pkg.sv
// Shared integer-pipeline types: register address width, writeback request
// record and the writeback source used by the arbiter's last-grant pointer.
package diablo_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/int_scoreboard.sv
// Busy-bit scoreboard for the integer register file: one bit per register,
// set on issue, cleared on writeback, wiped on flush, with three lookup ports.
module int_scoreboard
  import diablo_pkg::*;
#(
  parameter int unsigned NREG = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en_in,
  input  logic [REG_ADDR_W-1:0] set_addr_in,
  input  logic                  clr_en_in,
  input  logic [REG_ADDR_W-1:0] clr_addr_in,
  input  logic                  flush_in,
  input  logic [REG_ADDR_W-1:0] look_a_in,
  input  logic [REG_ADDR_W-1:0] look_b_in,
  input  logic [REG_ADDR_W-1:0] look_c_in,
  output logic                  hit_a_out,
  output logic                  hit_b_out,
  output logic                  hit_c_out,
  output logic [NREG-1:0]       busy_out
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Order matters: clear, then set (a new producer outranks the retiring
  // one), then flush over everything; x0 never tracks a producer.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_in) busy_d[clr_addr_in] = 1'b0;
    if (set_en_in) busy_d[set_addr_in] = 1'b1;
    if (flush_in)  busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign hit_a_out = (look_a_in != '0) & busy_q[look_a_in];
  assign hit_b_out = (look_b_in != '0) & busy_q[look_b_in];
  assign hit_c_out = (look_c_in != '0) & busy_q[look_c_in];
  assign busy_out  = busy_q;

endmodule

// File: rtl/int_wb_arbiter.sv
// Round-robin ALU/LSU arbiter for the integer regfile write port, with a
// registered write stage and scoreboard-driven RAW/WAW issue stall.
module int_wb_arbiter
  import diablo_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid_in,
  input  logic [REG_ADDR_W-1:0] alu_rd_in,
  input  logic [XLEN-1:0]       alu_data_in,
  output logic                  alu_ready_out,
  input  logic                  lsu_valid_in,
  input  logic [REG_ADDR_W-1:0] lsu_rd_in,
  input  logic [XLEN-1:0]       lsu_data_in,
  output logic                  lsu_ready_out,
  input  logic                  issue_valid_in,
  input  logic [REG_ADDR_W-1:0] issue_rd_in,
  input  logic [REG_ADDR_W-1:0] rs1_addr_in,
  input  logic [REG_ADDR_W-1:0] rs2_addr_in,
  input  logic                  flush_in,
  output logic                  stall_out,
  output logic [REG_ADDR_W-1:0] waddr_out,
  output logic [XLEN-1:0]       wdata_out,
  output logic                  wen_out,
  output logic [NREG-1:0]       busy_out
);

  wb_req_t alu_req;
  wb_req_t lsu_req;
  wb_req_t win_req;
  wb_src_e last_q, last_d;

  logic                  grant_alu;
  logic                  grant_lsu;
  logic                  accepted;
  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;

  logic rs1_busy, rs2_busy, rd_busy;
  logic set_en;

  always_comb begin
    alu_req = '{valid: alu_valid_in, rd: alu_rd_in, data: alu_data_in};
    lsu_req = '{valid: lsu_valid_in, rd: lsu_rd_in, data: lsu_data_in};

    // On a tie the source not granted last wins.
    grant_alu = alu_req.valid & (~lsu_req.valid | (last_q == WB_LSU));
    grant_lsu = lsu_req.valid & ~grant_alu;
    accepted  = grant_alu | grant_lsu;
    win_req   = grant_lsu ? lsu_req : alu_req;

    last_d = last_q;
    if (grant_alu)      last_d = WB_ALU;
    else if (grant_lsu) last_d = WB_LSU;

    wen_d   = accepted & (win_req.rd != '0);
    waddr_d = accepted ? win_req.rd   : waddr_q;
    wdata_d = accepted ? win_req.data : wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= WB_LSU;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      last_q  <= last_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign alu_ready_out = grant_alu & ~rst;
  assign lsu_ready_out = grant_lsu & ~rst;
  assign wen_out       = wen_q;
  assign waddr_out     = waddr_q;
  assign wdata_out     = wdata_q;

  assign stall_out = ~rst & (rs1_busy | rs2_busy | (issue_valid_in & rd_busy));
  assign set_en    = issue_valid_in & (issue_rd_in != '0) & ~stall_out;

  int_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en_in   (set_en),
    .set_addr_in (issue_rd_in),
    .clr_en_in   (wen_q),
    .clr_addr_in (waddr_q),
    .flush_in    (flush_in),
    .look_a_in   (rs1_addr_in),
    .look_b_in   (rs2_addr_in),
    .look_c_in   (issue_rd_in),
    .hit_a_out   (rs1_busy),
    .hit_b_out   (rs2_busy),
    .hit_c_out   (rd_busy),
    .busy_out    (busy_out)
  );

endmodule

// File: tb/tb_int_wb_arbiter.sv
// Directed scenarios plus a randomized run of int_wb_arbiter against a
// cycle-level reference model of arbitration, write stage and scoreboard.
module tb_int_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_in;
  logic [4:0]  alu_rd_in;
  logic [31:0] alu_data_in;
  logic        alu_ready_out;
  logic        lsu_valid_in;
  logic [4:0]  lsu_rd_in;
  logic [31:0] lsu_data_in;
  logic        lsu_ready_out;
  logic        issue_valid_in;
  logic [4:0]  issue_rd_in;
  logic [4:0]  rs1_addr_in;
  logic [4:0]  rs2_addr_in;
  logic        flush_in;
  logic        stall_out;
  logic [4:0]  waddr_out;
  logic [31:0] wdata_out;
  logic        wen_out;
  logic [31:0] busy_out;

  int vectors = 0;
  int errors  = 0;

  int_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid_in   (alu_valid_in),
    .alu_rd_in      (alu_rd_in),
    .alu_data_in    (alu_data_in),
    .alu_ready_out  (alu_ready_out),
    .lsu_valid_in   (lsu_valid_in),
    .lsu_rd_in      (lsu_rd_in),
    .lsu_data_in    (lsu_data_in),
    .lsu_ready_out  (lsu_ready_out),
    .issue_valid_in (issue_valid_in),
    .issue_rd_in    (issue_rd_in),
    .rs1_addr_in    (rs1_addr_in),
    .rs2_addr_in    (rs2_addr_in),
    .flush_in       (flush_in),
    .stall_out      (stall_out),
    .waddr_out      (waddr_out),
    .wdata_out      (wdata_out),
    .wen_out        (wen_out),
    .busy_out       (busy_out)
  );

  always #5 clk = ~clk;

  task automatic idle();
    alu_valid_in = 0; alu_rd_in = 0; alu_data_in = 0;
    lsu_valid_in = 0; lsu_rd_in = 0; lsu_data_in = 0;
    issue_valid_in = 0; issue_rd_in = 0;
    rs1_addr_in = 0; rs2_addr_in = 0; flush_in = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    alu_valid_in = 1; alu_rd_in = 3;
    lsu_valid_in = 1; lsu_rd_in = 4;
    issue_valid_in = 1; issue_rd_in = 6; rs1_addr_in = 6;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (alu_ready_out !== 1'b0) begin errors++; $display("FAIL reset_alu_ready got %b exp 0", alu_ready_out); end
    vectors++; if (lsu_ready_out !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready got %b exp 0", lsu_ready_out); end
    vectors++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_out); end
    vectors++; if (wen_out !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", wen_out); end
    vectors++; if (waddr_out !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", waddr_out); end
    vectors++; if (wdata_out !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", wdata_out); end
    vectors++; if (busy_out !== 32'd0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy_out); end
    idle();
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_alu_only();
    do_reset();
    alu_valid_in = 1; alu_rd_in = 5; alu_data_in = 32'hDEADBEEF;
    #1;
    vectors++; if (alu_ready_out !== 1'b1) begin errors++; $display("FAIL alu_only_ready got %b exp 1", alu_ready_out); end
    @(negedge clk);
    idle();
    vectors++; if (wen_out !== 1'b1) begin errors++; $display("FAIL alu_only_wen got %b exp 1", wen_out); end
    vectors++; if (waddr_out !== 5'd5) begin errors++; $display("FAIL alu_only_waddr got %0d exp 5", waddr_out); end
    vectors++; if (wdata_out !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_only_wdata got %h exp deadbeef", wdata_out); end
    @(negedge clk);
    vectors++; if (wen_out !== 1'b0) begin errors++; $display("FAIL alu_only_wen_pulse got %b exp 0", wen_out); end
  endtask

  task automatic test_contention();
    do_reset();
    alu_valid_in = 1; alu_rd_in = 3; alu_data_in = 32'hA0A0A0A0;
    lsu_valid_in = 1; lsu_rd_in = 4; lsu_data_in = 32'h5B5B5B5B;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (alu_ready_out !== ((k % 2) == 0)) begin errors++; $display("FAIL contention_alu_ready[%0d] got %b exp %b", k, alu_ready_out, (k % 2) == 0); end
      vectors++; if (lsu_ready_out !== ((k % 2) == 1)) begin errors++; $display("FAIL contention_lsu_ready[%0d] got %b exp %b", k, lsu_ready_out, (k % 2) == 1); end
      @(negedge clk);
      vectors++; if (wen_out !== 1'b1 || waddr_out !== ((k % 2) == 0 ? 5'd3 : 5'd4)) begin
        errors++; $display("FAIL contention_write[%0d] got wen=%b addr=%0d exp wen=1 addr=%0d", k, wen_out, waddr_out, (k % 2) == 0 ? 3 : 4);
      end
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_x0();
    do_reset();
    issue_valid_in = 1; issue_rd_in = 6;
    @(negedge clk);
    idle();
    lsu_valid_in = 1; lsu_rd_in = 0; lsu_data_in = 32'h1234;
    #1;
    vectors++; if (lsu_ready_out !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", lsu_ready_out); end
    @(negedge clk);
    idle();
    vectors++; if (wen_out !== 1'b0) begin errors++; $display("FAIL x0_wen got %b exp 0", wen_out); end
    vectors++; if (busy_out !== 32'h40) begin errors++; $display("FAIL x0_busy got %h exp 00000040", busy_out); end
  endtask

  task automatic test_raw_stall();
    do_reset();
    issue_valid_in = 1; issue_rd_in = 7;                 // cycle 1
    #1;
    vectors++; if (stall_out !== 1'b0) begin errors++; $display("FAIL raw_issue_stall got %b exp 0", stall_out); end
    @(negedge clk);
    idle(); rs1_addr_in = 7;                             // cycle 2
    #1;
    vectors++; if (stall_out !== 1'b1) begin errors++; $display("FAIL raw_stall_c2 got %b exp 1", stall_out); end
    @(negedge clk);                                       // cycle 3
    #1;
    vectors++; if (stall_out !== 1'b1) begin errors++; $display("FAIL raw_stall_c3 got %b exp 1", stall_out); end
    @(negedge clk);                                       // cycle 4
    alu_valid_in = 1; alu_rd_in = 7; alu_data_in = 32'h77;
    #1;
    vectors++; if (alu_ready_out !== 1'b1) begin errors++; $display("FAIL raw_alu_ready got %b exp 1", alu_ready_out); end
    @(negedge clk);                                       // cycle 5
    alu_valid_in = 0;
    #1;
    vectors++; if (wen_out !== 1'b1 || waddr_out !== 5'd7) begin errors++; $display("FAIL raw_wen_c5 got wen=%b addr=%0d exp wen=1 addr=7", wen_out, waddr_out); end
    vectors++; if (stall_out !== 1'b1) begin errors++; $display("FAIL raw_stall_c5 got %b exp 1", stall_out); end
    @(negedge clk);                                       // cycle 6
    #1;
    vectors++; if (stall_out !== 1'b0) begin errors++; $display("FAIL raw_stall_c6 got %b exp 0", stall_out); end
    vectors++; if (busy_out !== 32'd0) begin errors++; $display("FAIL raw_busy_c6 got %h exp 0", busy_out); end
    idle();
  endtask

  task automatic test_set_clear();
    do_reset();
    alu_valid_in = 1; alu_rd_in = 9; alu_data_in = 32'h99;
    @(negedge clk);
    idle();
    issue_valid_in = 1; issue_rd_in = 9;
    #1;
    vectors++; if (wen_out !== 1'b1 || waddr_out !== 5'd9) begin errors++; $display("FAIL setclr_wen got wen=%b addr=%0d exp wen=1 addr=9", wen_out, waddr_out); end
    vectors++; if (stall_out !== 1'b0) begin errors++; $display("FAIL setclr_stall got %b exp 0", stall_out); end
    @(negedge clk);
    idle();
    vectors++; if (busy_out !== 32'h200) begin errors++; $display("FAIL setclr_busy got %h exp 00000200", busy_out); end
  endtask

  task automatic test_flush();
    do_reset();
    issue_valid_in = 1; issue_rd_in = 2; @(negedge clk);
    issue_rd_in = 5; @(negedge clk);
    issue_rd_in = 9; @(negedge clk);
    idle();
    vectors++; if (busy_out !== 32'h224) begin errors++; $display("FAIL flush_pre_busy got %h exp 00000224", busy_out); end
    alu_valid_in = 1; alu_rd_in = 5; alu_data_in = 32'h55;
    @(negedge clk);
    idle();
    flush_in = 1;
    issue_valid_in = 1; issue_rd_in = 11;
    lsu_valid_in = 1; lsu_rd_in = 12; lsu_data_in = 32'hC0FFEE;
    #1;
    vectors++; if (wen_out !== 1'b1 || waddr_out !== 5'd5) begin errors++; $display("FAIL flush_pending_wen got wen=%b addr=%0d exp wen=1 addr=5", wen_out, waddr_out); end
    vectors++; if (lsu_ready_out !== 1'b1) begin errors++; $display("FAIL flush_lsu_ready got %b exp 1", lsu_ready_out); end
    @(negedge clk);
    idle();
    vectors++; if (busy_out !== 32'd0) begin errors++; $display("FAIL flush_busy got %h exp 0", busy_out); end
    vectors++; if (wen_out !== 1'b1 || waddr_out !== 5'd12 || wdata_out !== 32'hC0FFEE) begin
      errors++; $display("FAIL flush_lsu_write got wen=%b addr=%0d data=%h exp wen=1 addr=12 data=00c0ffee", wen_out, waddr_out, wdata_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_valid_in = 1; issue_rd_in = 3;
    alu_valid_in = 1; alu_rd_in = 8; alu_data_in = 32'h88;
    @(negedge clk);
    idle();
    vectors++; if (wen_out !== 1'b1 || busy_out !== 32'h8) begin errors++; $display("FAIL rstmid_pre got wen=%b busy=%h exp wen=1 busy=00000008", wen_out, busy_out); end
    #2 rst = 1;
    #1;
    vectors++; if (busy_out !== 32'd0) begin errors++; $display("FAIL rstmid_busy got %h exp 0", busy_out); end
    vectors++; if (wen_out !== 1'b0) begin errors++; $display("FAIL rstmid_wen got %b exp 0", wen_out); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_random();
    logic [31:0] m_busy;
    bit          m_last_lsu;
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          exp_ga, exp_gl, exp_stall;
    bit          alu_hold, lsu_hold;
    do_reset();
    m_busy = 0; m_last_lsu = 1; m_wen = 0; m_waddr = 0; m_wdata = 0;
    alu_hold = 0; lsu_hold = 0;
    for (int c = 0; c < 600; c++) begin
      vectors++; if (wen_out !== m_wen) begin errors++; $display("FAIL rand_wen[%0d] got %b exp %b", c, wen_out, m_wen); end
      if (m_wen) begin
        vectors++; if (waddr_out !== m_waddr || wdata_out !== m_wdata) begin
          errors++; $display("FAIL rand_write[%0d] got addr=%0d data=%h exp addr=%0d data=%h", c, waddr_out, wdata_out, m_waddr, m_wdata);
        end
      end
      vectors++; if (busy_out !== m_busy) begin errors++; $display("FAIL rand_busy[%0d] got %h exp %h", c, busy_out, m_busy); end

      if (!alu_hold) begin
        alu_valid_in = ($urandom_range(0, 2) != 0);
        alu_rd_in    = 5'($urandom_range(0, 7));
        alu_data_in  = $urandom;
      end
      if (!lsu_hold) begin
        lsu_valid_in = ($urandom_range(0, 2) != 0);
        lsu_rd_in    = 5'($urandom_range(0, 7));
        lsu_data_in  = $urandom;
      end
      issue_valid_in = ($urandom_range(0, 1) != 0);
      issue_rd_in    = 5'($urandom_range(0, 7));
      rs1_addr_in    = 5'($urandom_range(0, 9));
      rs2_addr_in    = 5'($urandom_range(0, 9));
      flush_in       = ($urandom_range(0, 24) == 0);
      #1;

      if (alu_valid_in && lsu_valid_in) begin
        exp_ga = m_last_lsu; exp_gl = !m_last_lsu;
      end else begin
        exp_ga = alu_valid_in; exp_gl = lsu_valid_in;
      end
      exp_stall = (rs1_addr_in != 0 && m_busy[rs1_addr_in]) ||
                  (rs2_addr_in != 0 && m_busy[rs2_addr_in]) ||
                  (issue_valid_in && issue_rd_in != 0 && m_busy[issue_rd_in]);
      vectors++; if (alu_ready_out !== exp_ga || lsu_ready_out !== exp_gl) begin
        errors++; $display("FAIL rand_ready[%0d] got alu=%b lsu=%b exp alu=%b lsu=%b", c, alu_ready_out, lsu_ready_out, exp_ga, exp_gl);
      end
      vectors++; if (stall_out !== exp_stall) begin errors++; $display("FAIL rand_stall[%0d] got %b exp %b", c, stall_out, exp_stall); end

      if (m_wen) m_busy[m_waddr] = 1'b0;
      if (issue_valid_in && issue_rd_in != 0 && !exp_stall) m_busy[issue_rd_in] = 1'b1;
      if (flush_in) m_busy = 0;
      m_wen = 0;
      if (exp_ga) begin
        m_wen = (alu_rd_in != 0); m_waddr = alu_rd_in; m_wdata = alu_data_in; m_last_lsu = 0;
      end else if (exp_gl) begin
        m_wen = (lsu_rd_in != 0); m_waddr = lsu_rd_in; m_wdata = lsu_data_in; m_last_lsu = 1;
      end
      alu_hold = alu_valid_in && !exp_ga;
      lsu_hold = lsu_valid_in && !exp_gl;
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_alu_only();
    test_contention();
    test_x0();
    test_raw_stall();
    test_set_clear();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/int_wb_arbiter.md
# int_wb_arbiter

Shares the single write port of the integer register file between the ALU and LSU writeback paths. Tracks outstanding destination registers in a scoreboard so the issue stage stalls on RAW and WAW hazards. Sits between the execute/memory units and `int_regfile`. Its `waddr_out`, `wdata_out` and `wen_out` ports drive the regfile write port directly.

## Interface
Parameters:
- XLEN, 32, data width of a register.
- NREG, 32, number of architectural registers; address width is 5.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- alu_valid_in  in  1  ALU writeback request.
- alu_rd_in  in  5  ALU destination register.
- alu_data_in  in  XLEN  ALU result.
- alu_ready_out  out  1  ALU request accepted this cycle.
- lsu_valid_in  in  1  LSU writeback request.
- lsu_rd_in  in  5  LSU destination register.
- lsu_data_in  in  XLEN  load data.
- lsu_ready_out  out  1  LSU request accepted this cycle.
- issue_valid_in  in  1  an instruction with a destination issues this cycle.
- issue_rd_in  in  5  its destination register.
- rs1_addr_in  in  5  source 1 of the instruction at issue.
- rs2_addr_in  in  5  source 2 of the instruction at issue.
- flush_in  in  1  pipeline flush; discards scoreboard state.
- stall_out  out  1  issue must hold.
- waddr_out  out  5  regfile write address.
- wdata_out  out  XLEN  regfile write data.
- wen_out  out  1  regfile write enable.
- busy_out  out  NREG  scoreboard vector; bit i set means a write to xi is outstanding.

## Operation
- Arbitration:
  - Round-robin between ALU and LSU using a one-bit last-grant pointer.
  - When both are valid, the requester not granted last wins.
  - When one is valid, it wins and the pointer updates to it.
  - At most one grant per cycle.
  - ready_out is combinational: ready = grant. A requester holds valid, rd and data stable until ready.
- Output stage: the accepted request is registered into waddr_out/wdata_out/wen_out.
- x0 requests:
  - A request with rd = 0 is accepted normally (ready asserted, pointer updates).
  - wen_out stays 0 for it; waddr_out/wdata_out are don't-care.
- Scoreboard:
  - issue_valid_in with issue_rd_in ≠ 0 and stall_out = 0 sets busy[rd] at the clock edge.
  - wen_out = 1 clears busy[waddr_out] at the clock edge.
  - Set and clear of the same bit in one cycle: set wins, because a new producer is outstanding.
  - busy[0] is constant 0.
- stall_out is combinational: busy[rs1] | busy[rs2] | (issue_valid_in & busy[issue_rd]).
  - Each term is gated by a nonzero address.
  - There is no forwarding inside this block.
- flush_in:
  - Clears all busy bits at the edge. Flush has priority over a same-cycle set.
  - Writebacks already in the output register still complete.
  - Requests presented during flush are still arbitrated and written.
- Reset (asynchronous):
  - wen_out = 0, waddr_out = 0, wdata_out = 0, busy_out = 0.
  - Last-grant pointer = LSU, so the ALU wins the first tie.
  - alu_ready_out and lsu_ready_out are 0 while rst is high.
  - stall_out = 0 while rst is high.

## Timing
- A request accepted in cycle N (valid & ready) drives wen_out = 1 in cycle N+1 for exactly one cycle. The regfile captures it at the end of N+1.
- busy[rd] clears at the end of N+1, so stall_out drops in N+2. That is the first cycle a regfile read returns the new value.
- busy set at the end of issue cycle M is visible as stall in M+1.
- Throughput: one write per cycle. With both requesters continuously valid, grants alternate ALU, LSU, ALU, ...
- Reset asserted mid-operation:
  - A pending wen_out pulse is dropped.
  - The scoreboard clears immediately, with no wait for a clock edge.

## Structure
- Shared package `diablo_pkg`:
  - `REG_ADDR_W = 5`, `XLEN`.
  - `wb_req_t` struct {valid, rd, data}.
  - `wb_src_e` enum {WB_ALU, WB_LSU}, used for the last-grant pointer.
- One sub-module: `int_scoreboard`.
  - Holds the busy vector with its set/clear/flush priority.
  - Provides three combinational lookup ports feeding stall_out.
- Arbitration and the output register stay in the top module.

## Test plan
- ALU only: alu_valid_in=1, rd=5, data=0xDEADBEEF in cycle 1 → alu_ready_out=1 in cycle 1; wen_out=1, waddr_out=5, wdata_out=0xDEADBEEF in cycle 2 only.
- Contention: ALU (rd=3) and LSU (rd=4) both valid for 4 cycles after reset → grant order ALU, LSU, ALU, LSU; each requester is ready only in its grant cycle.
- x0 write: LSU rd=0, data=0x1234 → lsu_ready_out=1; wen_out stays 0 the next cycle; busy_out unchanged.
- RAW stall: issue rd=7 in cycle 1, then rs1=7 from cycle 2 → stall_out=1 in cycle 2. ALU writeback of x7 accepted in cycle 4 → wen_out in cycle 5, stall_out=0 in cycle 6.
- Simultaneous set/clear: wen_out for x9 in the same cycle as a new issue of rd=9 → busy[9] remains 1 afterward.
- Flush and reset: busy bits 2, 5, 9 set, flush_in=1 for one cycle → busy_out=0 next cycle, and a pending wen_out still pulses. rst asserted mid-cycle → busy_out=0, wen_out=0 immediately.
